ysyx_25040101_pc_gen: RTL and testbench

Parametrised next-PC generator that supersedes the combinational PC adder. It owns the architectural fetch PC register and computes redirect targets as base + offset, with a JALR-style bit-0 clear. It checks target alignment, arbitrates trap, redirect and sequential advance, and offers the PC to fetch over a valid/ready handshake. It sits between the control unit / execute stage (redirect sources) and the instruction-fetch stage.

---
 rtl/ysyx_25040101_pc_gen_pkg.sv | 20 ++
 rtl/ysyx_25040101_pc_target.sv | 32 +++
 rtl/ysyx_25040101_pc_gen.sv | 116 +++++++++++
 tb/tb_ysyx_25040101_pc_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040101_pc_gen_pkg.sv
// Shared definitions for the next-PC generator and its target adder.
//   pc_state_e          : FSM state encoding (BOOT / RUN / HALT).
//   DEFAULT_RESET_VEC   : default first fetch address after reset.
//   ialign_bits()       : number of low target bits that must be zero for a
//                         given instruction alignment in bytes (2 -> 1, 4 -> 2).
package ysyx_25040101_pc_gen_pkg;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;

    function automatic int unsigned ialign_bits(input int unsigned ialign);
        return (ialign >= 4) ? 2 : 1;
    endfunction

endpackage

// File: rtl/ysyx_25040101_pc_target.sv
// Redirect target adder with JALR bit-0 clear and alignment check.
// Purely combinational; also reused by execute for branch prediction checks.
//   base       in  XLEN  target base (pc or rs1)
//   offset     in  XLEN  target offset (immediate)
//   jalr       in  1     clear bit 0 of the sum
//   target     out XLEN  base + offset (mod 2^XLEN), bit 0 cleared for JALR
//   misaligned out 1     target violates IALIGN
module ysyx_25040101_pc_target
    import ysyx_25040101_pc_gen_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 4
) (
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] offset,
    input  logic            jalr,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    localparam int unsigned LowBits = ialign_bits(IALIGN);

    logic [XLEN-1:0] sum;

    always_comb begin
        sum        = base + offset;
        target     = {sum[XLEN-1:1], sum[0] & ~jalr};
        // Alignment is judged after the JALR mask, so a JALR sum of ...2 is fine at IALIGN=2.
        misaligned = |target[LowBits-1:0];
    end

endmodule

// File: rtl/ysyx_25040101_pc_gen.sv
// Next-PC generator: owns the fetch PC register, arbitrates halt > trap >
// redirect > sequential advance, and offers the PC to fetch over valid/ready.
//   clock, reset          system clock, synchronous active-high reset
//   redir_*_i             redirect request (base + offset, optional JALR mask)
//   trap_valid_i/vec_i    trap / mret redirect, low bits forced to alignment
//   halt_i                stop fetching until reset
//   pc_o/pc_valid_o       PC offered to fetch; pc_ready_i accepts it
//   misalign_o            one-cycle pulse for a dropped misaligned redirect
//   misalign_addr_o       last offending target, held until the next pulse
//   halted_o              block is in HALT
module ysyx_25040101_pc_gen
    import ysyx_25040101_pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = DEFAULT_RESET_VEC,
    parameter int unsigned     IALIGN    = 4,
    parameter int unsigned     STEP      = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redir_valid_i,
    input  logic [XLEN-1:0] redir_base_i,
    input  logic [XLEN-1:0] redir_offset_i,
    input  logic            redir_jalr_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o,
    output logic            halted_o
);

    localparam int unsigned LowBits = ialign_bits(IALIGN);

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic            pc_valid_q;
    logic            misalign_q;
    logic [XLEN-1:0] misalign_addr_q;
    logic            halted_q;

    logic [XLEN-1:0] redir_target;
    logic            redir_misaligned;
    logic [XLEN-1:0] trap_target;

    ysyx_25040101_pc_target #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_pc_target (
        .base       (redir_base_i),
        .offset     (redir_offset_i),
        .jalr       (redir_jalr_i),
        .target     (redir_target),
        .misaligned (redir_misaligned)
    );

    assign trap_target = {trap_vec_i[XLEN-1:LowBits], LowBits'(0)};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StBoot;
            pc_q            <= RESET_VEC;
            pc_valid_q      <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            halted_q        <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            unique case (state_q)
                StBoot: begin
                    state_q    <= StRun;
                    pc_q       <= RESET_VEC;
                    pc_valid_q <= 1'b1;
                end
                StRun: begin
                    if (halt_i) begin
                        state_q    <= StHalt;
                        pc_valid_q <= 1'b0;
                        halted_q   <= 1'b1;
                    end else if (trap_valid_i) begin
                        // Flush: replaces the offered PC whether or not it was accepted.
                        pc_q       <= trap_target;
                        pc_valid_q <= 1'b1;
                    end else if (redir_valid_i) begin
                        if (redir_misaligned) begin
                            // Redirect dropped; PC holds even if fetch accepted it this cycle.
                            misalign_q      <= 1'b1;
                            misalign_addr_q <= redir_target;
                        end else begin
                            pc_q       <= redir_target;
                            pc_valid_q <= 1'b1;
                        end
                    end else if (pc_valid_q && pc_ready_i) begin
                        pc_q <= pc_q + XLEN'(STEP);
                    end
                end
                StHalt: begin
                end
                default: begin
                    state_q    <= StBoot;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = pc_valid_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
    assign halted_o        = halted_q;

endmodule

// File: tb/tb_ysyx_25040101_pc_gen.sv
module tb_ysyx_25040101_pc_gen;

    logic        clock;
    logic        reset;
    logic        redir_valid_i;
    logic [31:0] redir_base_i;
    logic [31:0] redir_offset_i;
    logic        redir_jalr_i;
    logic        trap_valid_i;
    logic [31:0] trap_vec_i;
    logic        halt_i;
    logic        pc_ready_i;

    logic [31:0] pc4, pc2;
    logic        valid4, valid2;
    logic        mis4, mis2;
    logic [31:0] maddr4, maddr2;
    logic        halted4, halted2;

    int n_vec = 0;
    int n_err = 0;

    ysyx_25040101_pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h8000_0000),
        .IALIGN    (4),
        .STEP      (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .redir_valid_i   (redir_valid_i),
        .redir_base_i    (redir_base_i),
        .redir_offset_i  (redir_offset_i),
        .redir_jalr_i    (redir_jalr_i),
        .trap_valid_i    (trap_valid_i),
        .trap_vec_i      (trap_vec_i),
        .halt_i          (halt_i),
        .pc_o            (pc4),
        .pc_valid_o      (valid4),
        .pc_ready_i      (pc_ready_i),
        .misalign_o      (mis4),
        .misalign_addr_o (maddr4),
        .halted_o        (halted4)
    );

    // Same stimulus, IALIGN = 2 (compressed-capable fetch).
    ysyx_25040101_pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h8000_0000),
        .IALIGN    (2),
        .STEP      (4)
    ) dut_c (
        .clock           (clock),
        .reset           (reset),
        .redir_valid_i   (redir_valid_i),
        .redir_base_i    (redir_base_i),
        .redir_offset_i  (redir_offset_i),
        .redir_jalr_i    (redir_jalr_i),
        .trap_valid_i    (trap_valid_i),
        .trap_vec_i      (trap_vec_i),
        .halt_i          (halt_i),
        .pc_o            (pc2),
        .pc_valid_o      (valid2),
        .pc_ready_i      (pc_ready_i),
        .misalign_o      (mis2),
        .misalign_addr_o (maddr2),
        .halted_o        (halted2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        redir_valid_i  = 1'b0;
        redir_base_i   = '0;
        redir_offset_i = '0;
        redir_jalr_i   = 1'b0;
        trap_valid_i   = 1'b0;
        trap_vec_i     = '0;
        halt_i         = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] base, input logic [31:0] off, input logic jalr);
        redir_valid_i  = 1'b1;
        redir_base_i   = base;
        redir_offset_i = off;
        redir_jalr_i   = jalr;
    endtask

    initial begin
        idle_inputs();
        reset      = 1'b1;
        pc_ready_i = 1'b1;
        step();
        step();

        // Reset state (BOOT cycle, nothing offered yet)
        check_eq("rst_pc", pc4, 32'h8000_0000);
        check_eq("rst_valid", {31'd0, valid4}, 32'd0);
        check_eq("rst_misalign", {31'd0, mis4}, 32'd0);
        check_eq("rst_maddr", maddr4, 32'd0);
        check_eq("rst_halted", {31'd0, halted4}, 32'd0);

        reset = 1'b0;
        step();
        check_eq("boot_valid", {31'd0, valid4}, 32'd1);
        check_eq("boot_pc", pc4, 32'h8000_0000);
        step();
        check_eq("seq_pc1", pc4, 32'h8000_0004);
        step();
        check_eq("seq_pc2", pc4, 32'h8000_0008);

        // Stall: PC must hold
        pc_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_pc", pc4, 32'h8000_0008);
        end

        // Wrap: redirect to 0xFFFF_FFFC, then accept it
        redirect(32'hFFFF_FFF0, 32'h0000_000C, 1'b0);
        step();
        check_eq("wrap_setup_pc", pc4, 32'hFFFF_FFFC);
        idle_inputs();
        pc_ready_i = 1'b1;
        step();
        check_eq("wrap_pc", pc4, 32'h0000_0000);
        check_eq("wrap_pc_c", pc2, 32'h0000_0000);

        // JALR mask: 0x8000_0103 -> 0x8000_0102
        pc_ready_i = 1'b0;
        redirect(32'h8000_0101, 32'h0000_0002, 1'b1);
        step();
        check_eq("jalr_mis4", {31'd0, mis4}, 32'd1);
        check_eq("jalr_maddr4", maddr4, 32'h8000_0102);
        check_eq("jalr_pc4_hold", pc4, 32'h0000_0000);
        check_eq("jalr_pc2", pc2, 32'h8000_0102);
        check_eq("jalr_mis2", {31'd0, mis2}, 32'd0);
        idle_inputs();
        step();
        check_eq("mis_pulse_end", {31'd0, mis4}, 32'd0);
        check_eq("maddr_held", maddr4, 32'h8000_0102);

        // Back-to-back misaligned redirects give consecutive pulses
        redirect(32'h8000_0000, 32'h0000_0001, 1'b0);
        step();
        check_eq("b2b_mis_a", {31'd0, mis4}, 32'd1);
        check_eq("b2b_addr_a", maddr4, 32'h8000_0001);
        redirect(32'h8000_0000, 32'h0000_0006, 1'b0);
        step();
        check_eq("b2b_mis_b", {31'd0, mis4}, 32'd1);
        check_eq("b2b_addr_b", maddr4, 32'h8000_0006);
        check_eq("b2b_pc4_hold", pc4, 32'h0000_0000);
        check_eq("b2b_pc2", pc2, 32'h8000_0006);

        // Trap beats redirect; low bits of vector forced to alignment
        redirect(32'h8000_2000, 32'h0000_0000, 1'b0);
        trap_valid_i = 1'b1;
        trap_vec_i   = 32'h8000_1003;
        step();
        check_eq("trap_pc4", pc4, 32'h8000_1000);
        check_eq("trap_pc2", pc2, 32'h8000_1002);
        check_eq("trap_valid", {31'd0, valid4}, 32'd1);
        idle_inputs();
        step();
        check_eq("trap_no_mis", {31'd0, mis4}, 32'd0);

        // Redirect while fetch is stalled
        redirect(32'h8000_0000, 32'h0000_0040, 1'b0);
        step();
        check_eq("stall_redir_pc", pc4, 32'h8000_0040);
        idle_inputs();
        step();
        check_eq("stall_redir_hold", pc4, 32'h8000_0040);

        // Reset mid-stall
        reset = 1'b1;
        step();
        check_eq("midrst_valid", {31'd0, valid4}, 32'd0);
        check_eq("midrst_pc", pc4, 32'h8000_0000);
        reset = 1'b0;
        step();
        check_eq("midrst_boot_pc", pc4, 32'h8000_0000);

        // Halt with simultaneous redirect
        halt_i = 1'b1;
        redirect(32'h8000_0200, 32'h0000_0000, 1'b0);
        step();
        check_eq("halt_valid", {31'd0, valid4}, 32'd0);
        check_eq("halt_flag", {31'd0, halted4}, 32'd1);
        check_eq("halt_pc", pc4, 32'h8000_0000);
        halt_i       = 1'b0;
        trap_valid_i = 1'b1;
        trap_vec_i   = 32'h8000_3000;
        pc_ready_i   = 1'b1;
        step();
        step();
        check_eq("halt_ignore_pc", pc4, 32'h8000_0000);
        check_eq("halt_ignore_valid", {31'd0, valid4}, 32'd0);
        check_eq("halt_ignore_flag", {31'd0, halted4}, 32'd1);
        idle_inputs();

        // Reset out of HALT
        reset = 1'b1;
        step();
        check_eq("unhalt_flag", {31'd0, halted4}, 32'd0);
        reset = 1'b0;
        step();
        check_eq("unhalt_valid", {31'd0, valid4}, 32'd1);
        check_eq("unhalt_pc", pc4, 32'h8000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
